sprite_mover_gen: RTL
=====================

Name: sprite_mover_gen

Overview:
- Parametrised successor to the fixed-size OLED sprite demo: one player sprite moved by the four push-buttons on a SCREEN_W x SCREEN_H display, blocked by one rectangular obstacle on all four sides.
- Adds configurable screen, sprite and obstacle geometry and step rate, a clamp-or-wrap edge mode, a sticky-or-hold direction mode, and a blocked status output.
- Everything runs on pixel_clk.
- Sits between the button debouncers/pixel-index generator and the OLED driver.

Parameters:
- SCREEN_W, 96, display width in pixels
- SCREEN_H, 64, display height in pixels
- SPR_W, 10, sprite width
- SPR_H, 10, sprite height
- START_X, 0, sprite reset x
- START_Y, 54, sprite reset y
- OBS_X, 66, obstacle left x
- OBS_Y, 0, obstacle top y
- OBS_W, 30, obstacle width
- OBS_H, 30, obstacle height
- MOVE_DIV, 104166, pixel_clk cycles per movement step (about 60 steps/s at 6.25 MHz)
- WRAP, 0, 0 = clamp at screen edges, 1 = wrap to the opposite edge
- STICKY, 1, 1 = keep moving after button release, 0 = stop on release
- SPR_COLOR, 16'h07E0, sprite RGB565 colour
- OBS_COLOR, 16'hF800, obstacle RGB565 colour
- BG_COLOR, 16'h0000, background RGB565 colour

Ports:
- pixel_clk  in  1  block clock
- reset  in  1  synchronous, active-high
- btnU, btnD, btnL, btnR  in  1 each  debounced buttons, already synchronous to pixel_clk
- x  in  clog2(SCREEN_W)  current pixel column
- y  in  clog2(SCREEN_H)  current pixel row
- frame_begin  in  1  one-cycle pulse at start of frame
- oled_data  out  16  registered RGB565 pixel
- sprite_x  out  clog2(SCREEN_W)  displayed sprite x
- sprite_y  out  clog2(SCREEN_H)  displayed sprite y
- blocked  out  1  last attempted step was refused

Behaviour:
Reset is synchronous, active-high, clock pixel_clk. On reset:
- Working and displayed position = (START_X, START_Y).
- Direction = NONE; step counter = 0.
- oled_data = BG_COLOR; blocked = 0.
- Reset mid-motion takes effect next edge; no partial step.

Direction register (states NONE/LEFT/RIGHT/UP/DOWN):
- Fresh rising edge of a button this cycle wins, priority L > R > U > D.
- Otherwise, any held button sets direction with the same priority.
- Otherwise, direction is held if STICKY=1, or becomes NONE if STICKY=0.

Step counter:
- Counts 0..MOVE_DIV-1 and wraps.
- step_tick asserts on the cycle count == MOVE_DIV-1.

On step_tick with direction != NONE:
- Form the candidate position one pixel in that direction.
- Edge handling when the candidate leaves the screen:
  - WRAP=0: candidate is discarded, position unchanged, blocked unchanged.
  - WRAP=1: x<0 -> SCREEN_W-SPR_W; x>SCREEN_W-SPR_W -> 0; same rule for y with SCREEN_H/SPR_H.
- Collision: overlap of candidate [cx, cx+SPR_W) x [cy, cy+SPR_H) with [OBS_X, OBS_X+OBS_W) x [OBS_Y, OBS_Y+OBS_H), using half-open intervals.
  - On overlap: position unchanged, blocked <= 1.
  - Otherwise: position <= candidate, blocked <= 0.
- Touching edges (cx+SPR_W == OBS_X) is not a collision.

Arithmetic:
- All comparisons use clog2(max(SCREEN_W,SCREEN_H))+2 bit signed intermediates; no wrap-around aliasing.

Double buffering:
- sprite_x/sprite_y load from the working position only on cycles where frame_begin=1.
- If step_tick and frame_begin coincide, the displayed value is the pre-step working position.

Render:
- 1-cycle latency. oled_data at edge n+1 reflects x/y at edge n.
- Priority: sprite > obstacle > background, using the displayed position and half-open ranges.

Legality:
- Sprite must fit on screen; the start rectangle must not overlap the obstacle. The bench checks this with an assertion at elaboration/time 0.

Test Plan:
1. Defaults, MOVE_DIV=4, pulse btnR 1 cycle, STICKY=1 -> working x increments every 4 cycles from 0. frame_begin pulses at 10 and 30 cycles load sprite_x=2 then 7.
2. Place sprite at (55,10), hold btnR -> x moves to 56 (56+10 == 66 is touching, allowed). The next tick is refused: x stays 56, blocked=1. Then btnD until y=30: moving right is allowed again and blocked clears on the first successful step.
3. WRAP=0 at x=0, btnL -> x stays 0, blocked=0. WRAP=1 at x=0, btnL -> x=86 after one tick. WRAP=1 at y=54, btnD -> y=0.
4. Hold btnU and btnL together, then newly press btnD while both are held -> direction LEFT, then DOWN on btnD's rising edge. STICKY=0 with all buttons released -> no further steps.
5. Render with displayed sprite at (0,54): x=5,y=60 -> 16'h07E0 one cycle later; x=70,y=5 -> 16'hF800; x=40,y=40 -> 16'h0000.
6. Assert reset for 1 cycle mid-motion at x=37 -> next edge: sprite_x=0, sprite_y=54, blocked=0, oled_data=BG. No step for MOVE_DIV-1 cycles after release.

Source files
------------

// File: rtl/sprite_mover_gen.sv
// sprite_mover_gen
//   Moves one player sprite around a SCREEN_W x SCREEN_H display under
//   push-button control. A single rectangular obstacle blocks the sprite
//   from all four sides. The sprite colour, obstacle colour and background
//   colour are rendered into a registered RGB565 pixel stream.
//
// Ports
//   pixel_clk         block clock
//   reset             synchronous, active-high
//   btnU/D/L/R        debounced buttons, already synchronous to pixel_clk
//   x, y              pixel coordinate currently requested by the OLED driver
//   frame_begin       one-cycle pulse at frame start; loads the displayed position
//   oled_data         RGB565 pixel for (x, y) of the previous cycle
//   sprite_x/y        displayed (double-buffered) sprite position
//   blocked           1 when the last attempted step hit the obstacle
//   dir_state         current movement direction (debug view of the FSM)
//
// No valid/ready handshakes: frame_begin is a plain load strobe and the
// pixel path is a fixed one-cycle pipeline.
module sprite_mover_gen #(
  parameter int          SCREEN_W  = 96,
  parameter int          SCREEN_H  = 64,
  parameter int          SPR_W     = 10,
  parameter int          SPR_H     = 10,
  parameter int          START_X   = 0,
  parameter int          START_Y   = 54,
  parameter int          OBS_X     = 66,
  parameter int          OBS_Y     = 0,
  parameter int          OBS_W     = 30,
  parameter int          OBS_H     = 30,
  parameter int          MOVE_DIV  = 104166,
  parameter int          WRAP      = 0,
  parameter int          STICKY    = 1,
  parameter logic [15:0] SPR_COLOR = 16'h07E0,
  parameter logic [15:0] OBS_COLOR = 16'hF800,
  parameter logic [15:0] BG_COLOR  = 16'h0000
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic                        btnU,
  input  logic                        btnD,
  input  logic                        btnL,
  input  logic                        btnR,
  input  logic [$clog2(SCREEN_W)-1:0] x,
  input  logic [$clog2(SCREEN_H)-1:0] y,
  input  logic                        frame_begin,
  output logic [15:0]                 oled_data,
  output logic [$clog2(SCREEN_W)-1:0] sprite_x,
  output logic [$clog2(SCREEN_H)-1:0] sprite_y,
  output logic                        blocked,
  output logic [2:0]                  dir_state
);

  localparam int XW   = $clog2(SCREEN_W);
  localparam int YW   = $clog2(SCREEN_H);
  localparam int MAXD = (SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H;
  // Two spare bits: one for the sign of a step below zero, one so that
  // right/bottom edges plus sprite size never alias.
  localparam int SW   = $clog2(MAXD) + 2;
  localparam int CW   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  typedef logic signed [SW-1:0] coord_t;

  localparam coord_t X_MAX = coord_t'(SCREEN_W - SPR_W);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - SPR_H);
  localparam coord_t SPR_WS = coord_t'(SPR_W);
  localparam coord_t SPR_HS = coord_t'(SPR_H);
  localparam coord_t OBS_L = coord_t'(OBS_X);
  localparam coord_t OBS_R = coord_t'(OBS_X + OBS_W);
  localparam coord_t OBS_T = coord_t'(OBS_Y);
  localparam coord_t OBS_B = coord_t'(OBS_Y + OBS_H);

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  dir_t          dir, dir_next;
  logic [3:0]    btn, btn_q, rise;   // bit order {L, R, U, D} = priority order
  logic [CW-1:0] step_cnt;
  logic          step_tick;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  coord_t        wx_s, wy_s, cx, cy, nx, ny;
  coord_t        px, py, sx_s, sy_s;
  logic          off_x, off_y, edge_stop, hit, in_spr, in_obs;

  assign btn       = {btnL, btnR, btnU, btnD};
  assign rise      = btn & ~btn_q;
  assign step_tick = (step_cnt == CW'(MOVE_DIV - 1));
  assign dir_state = dir;

  // Direction FSM: state register
  always_ff @(posedge pixel_clk) begin
    if (reset) dir <= DIR_NONE;
    else       dir <= dir_next;
  end

  // Direction FSM: a fresh press beats a merely held button, so pressing a
  // new button while others are held redirects the sprite for that cycle.
  always_comb begin
    dir_next = dir;
    if      (rise[3]) dir_next = DIR_LEFT;
    else if (rise[2]) dir_next = DIR_RIGHT;
    else if (rise[1]) dir_next = DIR_UP;
    else if (rise[0]) dir_next = DIR_DOWN;
    else if (btn[3])  dir_next = DIR_LEFT;
    else if (btn[2])  dir_next = DIR_RIGHT;
    else if (btn[1])  dir_next = DIR_UP;
    else if (btn[0])  dir_next = DIR_DOWN;
    else if (STICKY == 0) dir_next = DIR_NONE;
  end

  // Candidate position, edge handling and obstacle test
  always_comb begin
    wx_s = coord_t'(wx);
    wy_s = coord_t'(wy);
    cx   = wx_s;
    cy   = wy_s;
    case (dir)
      DIR_LEFT:  cx = wx_s - coord_t'(1);
      DIR_RIGHT: cx = wx_s + coord_t'(1);
      DIR_UP:    cy = wy_s - coord_t'(1);
      DIR_DOWN:  cy = wy_s + coord_t'(1);
      default:   ;
    endcase
    nx    = cx;
    ny    = cy;
    off_x = 1'b0;
    off_y = 1'b0;
    if (cx[SW-1]) begin
      off_x = 1'b1;
      nx    = X_MAX;
    end else if (cx > X_MAX) begin
      off_x = 1'b1;
      nx    = '0;
    end
    if (cy[SW-1]) begin
      off_y = 1'b1;
      ny    = Y_MAX;
    end else if (cy > Y_MAX) begin
      off_y = 1'b1;
      ny    = '0;
    end
    edge_stop = (WRAP == 0) && (off_x || off_y);
    // Half-open overlap: touching edges do not count as a hit.
    hit = (nx < OBS_R) && (nx + SPR_WS > OBS_L) &&
          (ny < OBS_B) && (ny + SPR_HS > OBS_T);
  end

  // Pixel classification against the displayed (not working) position
  always_comb begin
    px     = coord_t'(x);
    py     = coord_t'(y);
    sx_s   = coord_t'(sprite_x);
    sy_s   = coord_t'(sprite_y);
    in_spr = (px >= sx_s) && (px < sx_s + SPR_WS) &&
             (py >= sy_s) && (py < sy_s + SPR_HS);
    in_obs = (px >= OBS_L) && (px < OBS_R) &&
             (py >= OBS_T) && (py < OBS_B);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      btn_q     <= '0;
      step_cnt  <= '0;
      wx        <= XW'(START_X);
      wy        <= YW'(START_Y);
      sprite_x  <= XW'(START_X);
      sprite_y  <= YW'(START_Y);
      blocked   <= 1'b0;
      oled_data <= BG_COLOR;
    end else begin
      btn_q    <= btn;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      // Loads the pre-step working position even when a step lands this edge.
      if (frame_begin) begin
        sprite_x <= wx;
        sprite_y <= wy;
      end
      // A clamped edge move is simply dropped and leaves blocked untouched.
      if (step_tick && dir != DIR_NONE && !edge_stop) begin
        if (hit) begin
          blocked <= 1'b1;
        end else begin
          wx      <= XW'(nx);
          wy      <= YW'(ny);
          blocked <= 1'b0;
        end
      end
      oled_data <= in_spr ? SPR_COLOR : (in_obs ? OBS_COLOR : BG_COLOR);
    end
  end

endmodule
